// File: rtl/pi_ctrl_mc.sv
// Multi-channel incremental PI controller: N_CH loops share one time-multiplexed
// datapath and one multiplier, each channel keeps its own error history and accumulator.
module pi_ctrl_mc #(
    parameter int N_CH    = 4,
    parameter int IN_W    = 12,
    parameter int DW      = 26,
    parameter int FRAC    = 8,
    parameter int OUT_MAX = 1000,
    parameter int OUT_MIN = 0,
    parameter int ADD_MAX = 100,
    parameter int ADD_MIN = -100,
    localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_ch,
    input  logic [IN_W-1:0]      in_sample,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [1:0]           cfg_sel,
    input  logic signed [DW-1:0] cfg_data,
    output logic                 out_valid,
    output logic [CW-1:0]        out_ch,
    output logic signed [DW-1:0] out_data,
    output logic [N_CH*DW-1:0]   out_all
);

    typedef enum logic [3:0] {
        S_IDLE, S_ERR, S_DIF, S_MP, S_MI, S_SUM, S_CLA, S_ACC, S_CLO, S_OUT
    } state_t;

    localparam logic signed [DW-1:0] SMAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SMIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] OMAX  = DW'(OUT_MAX);
    localparam logic signed [DW-1:0] OMIN  = DW'(OUT_MIN);
    localparam logic signed [DW-1:0] AMAX  = DW'(ADD_MAX);
    localparam logic signed [DW-1:0] AMIN  = DW'(ADD_MIN);
    localparam logic [CW:0]          CHLIM = (CW+1)'(N_CH);

    function automatic logic signed [DW-1:0] sat_wide(input logic signed [DW:0] s);
        if (s[DW] != s[DW-1]) return s[DW] ? SMIN : SMAX;
        return s[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] add_sat(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        logic signed [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        return sat_wide(s);
    endfunction

    function automatic logic signed [DW-1:0] sub_sat(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        logic signed [DW:0] s;
        s = {a[DW-1], a} - {b[DW-1], b};
        return sat_wide(s);
    endfunction

    function automatic logic signed [DW-1:0] clamp(input logic signed [DW-1:0] x,
                                                   input logic signed [DW-1:0] lo,
                                                   input logic signed [DW-1:0] hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    state_t state_q, state_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic [IN_W-1:0]      samp_q, samp_d;
    logic signed [DW-1:0] tgt_s_q, tgt_s_d, kp_s_q, kp_s_d, ki_s_q, ki_s_d;
    logic signed [DW-1:0] e0_q, e0_d, d_q, d_d, p_q, p_d, i_q, i_d;
    logic signed [DW-1:0] add_q, add_d, t_q, t_d;
    logic signed [DW-1:0] out_data_q, out_data_d;
    logic [CW-1:0]        out_ch_q, out_ch_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [DW-1:0] tgt_q [N_CH];
    logic signed [DW-1:0] tgt_d [N_CH];
    logic signed [DW-1:0] kp_q  [N_CH];
    logic signed [DW-1:0] kp_d  [N_CH];
    logic signed [DW-1:0] ki_q  [N_CH];
    logic signed [DW-1:0] ki_d  [N_CH];
    logic signed [DW-1:0] e1_q  [N_CH];
    logic signed [DW-1:0] e1_d  [N_CH];
    logic signed [DW-1:0] acc_q [N_CH];
    logic signed [DW-1:0] acc_d [N_CH];

    // Single shared multiplier: kp*d in MP, ki*e0 in MI.
    logic signed [DW-1:0]   mul_a, mul_b, mul_res;
    logic signed [2*DW-1:0] prod;
    always_comb begin
        mul_a = (state_q == S_MP) ? kp_s_q : ki_s_q;
        mul_b = (state_q == S_MP) ? d_q : e0_q;
        prod  = mul_a * mul_b;
        prod  = prod >>> FRAC;
        if (prod[2*DW-1:DW-1] == '0 || prod[2*DW-1:DW-1] == '1)
            mul_res = prod[DW-1:0];
        else
            mul_res = prod[2*DW-1] ? SMIN : SMAX;
    end

    logic signed [DW-1:0] clo_val;
    always_comb clo_val = clamp(t_q, OMIN, OMAX);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        samp_d      = samp_q;
        tgt_s_d     = tgt_s_q;
        kp_s_d      = kp_s_q;
        ki_s_d      = ki_s_q;
        e0_d        = e0_q;
        d_d         = d_q;
        p_d         = p_q;
        i_d         = i_q;
        add_d       = add_q;
        t_d         = t_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;
        tgt_d       = tgt_q;
        kp_d        = kp_q;
        ki_d        = ki_q;
        e1_d        = e1_q;
        acc_d       = acc_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && ({1'b0, in_ch} < CHLIM)) begin
                    ch_d    = in_ch;
                    samp_d  = in_sample;
                    tgt_s_d = tgt_q[in_ch];
                    kp_s_d  = kp_q[in_ch];
                    ki_s_d  = ki_q[in_ch];
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                e0_d    = sub_sat(tgt_s_q, {{(DW-IN_W){1'b0}}, samp_q});
                state_d = S_DIF;
            end
            S_DIF: begin
                d_d     = sub_sat(e0_q, e1_q[ch_q]);
                state_d = S_MP;
            end
            S_MP: begin
                p_d     = mul_res;
                state_d = S_MI;
            end
            S_MI: begin
                i_d         = mul_res;
                e1_d[ch_q]  = e0_q;
                state_d     = S_SUM;
            end
            S_SUM: begin
                add_d   = add_sat(p_q, i_q);
                state_d = S_CLA;
            end
            S_CLA: begin
                add_d   = clamp(add_q, AMIN, AMAX);
                state_d = S_ACC;
            end
            S_ACC: begin
                t_d     = add_sat(acc_q[ch_q], add_q);
                state_d = S_CLO;
            end
            S_CLO: begin
                // Storing the clamped value back is what prevents windup.
                acc_d[ch_q] = clo_val;
                out_data_d  = clo_val;
                out_ch_d    = ch_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            default: state_d = S_IDLE;
        endcase

        if (cfg_we && ({1'b0, cfg_ch} < CHLIM)) begin
            case (cfg_sel)
                2'd0:    tgt_d[cfg_ch] = cfg_data;
                2'd1:    kp_d[cfg_ch]  = cfg_data;
                2'd2:    ki_d[cfg_ch]  = cfg_data;
                default: ;
            endcase
        end

        if (clr) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            e1_d        = '{default: '0};
            acc_d       = '{default: '0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            samp_q      <= '0;
            tgt_s_q     <= '0;
            kp_s_q      <= '0;
            ki_s_q      <= '0;
            e0_q        <= '0;
            d_q         <= '0;
            p_q         <= '0;
            i_q         <= '0;
            add_q       <= '0;
            t_q         <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            tgt_q       <= '{default: '0};
            kp_q        <= '{default: '0};
            ki_q        <= '{default: '0};
            e1_q        <= '{default: '0};
            acc_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            samp_q      <= samp_d;
            tgt_s_q     <= tgt_s_d;
            kp_s_q      <= kp_s_d;
            ki_s_q      <= ki_s_d;
            e0_q        <= e0_d;
            d_q         <= d_d;
            p_q         <= p_d;
            i_q         <= i_d;
            add_q       <= add_d;
            t_q         <= t_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            tgt_q       <= tgt_d;
            kp_q        <= kp_d;
            ki_q        <= ki_d;
            e1_q        <= e1_d;
            acc_q       <= acc_d;
        end
    end

    // The accumulator always holds each channel's latest published output.
    always_comb begin
        out_all = '0;
        for (int unsigned k = 0; k < N_CH; k++) out_all[k*DW +: DW] = acc_q[k];
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_pi_ctrl_mc.sv
// Directed self-checking bench for pi_ctrl_mc with hand-computed expected outputs.
module tb_pi_ctrl_mc;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         in_ch = '0;
    logic [11:0]        in_sample = '0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_ch = '0;
    logic [1:0]         cfg_sel = '0;
    logic signed [25:0] cfg_data = '0;
    logic               out_valid;
    logic [1:0]         out_ch;
    logic signed [25:0] out_data;
    logic [103:0]       out_all;

    int checks = 0;
    int failures = 0;

    pi_ctrl_mc #(.N_CH(4), .IN_W(12), .DW(26), .FRAC(8), .OUT_MAX(1000), .OUT_MIN(0),
                 .ADD_MAX(100), .ADD_MIN(-100)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_sample(in_sample), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .out_valid(out_valid), .out_ch(out_ch),
        .out_data(out_data), .out_all(out_all)
    );

    always #5 clk = ~clk;

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] sel, input int val);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = 26'(val);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Waits (bounded) for in_ready, then offers one sample accepted at the next posedge.
    task automatic launch(input logic [1:0] ch, input int s);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1; in_ch = ch; in_sample = 12'(s);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic wait_out(output int lat, output logic signed [25:0] d, output logic [1:0] c);
        lat = -1; d = 'x; c = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k; d = out_data; c = out_ch;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
        checks++; if (out_data !== 26'sd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (out_all !== 104'd0) begin failures++; $display("FAIL reset_out_all got=%h exp=0", out_all); end
        rst_n = 1'b1;
    endtask

    task automatic test_t1;
        int lat; logic signed [25:0] d; logic [1:0] c;
        cfg_write(0, 0, 500);
        cfg_write(0, 1, 10 << 8);
        cfg_write(0, 2, 1 << 8);
        launch(0, 400);
        wait_out(lat, d, c);
        checks++; if (lat !== 9) begin failures++; $display("FAIL t1_latency got=%0d exp=9", lat); end
        checks++; if (d !== 26'sd100) begin failures++; $display("FAIL t1_out_data got=%0d exp=100", d); end
        checks++; if (c !== 2'd0) begin failures++; $display("FAIL t1_out_ch got=%0d exp=0", c); end
        checks++; if (out_all[25:0] !== 26'd100) begin failures++; $display("FAIL t1_out_all0 got=%0d exp=100", out_all[25:0]); end
    endtask

    task automatic test_t2;
        int lat; logic signed [25:0] d; logic [1:0] c;
        for (int r = 1; r <= 2; r++) begin
            launch(0, 400);
            wait_out(lat, d, c);
            checks++; if (d !== 26'(100 + 100 * r)) begin failures++; $display("FAIL t2_out_data got=%0d exp=%0d", d, 100 + 100 * r); end
        end
        checks++; if (out_all !== {26'd0, 26'd0, 26'd0, 26'd300}) begin failures++; $display("FAIL t2_out_all got=%h exp=%h", out_all, {26'd0, 26'd0, 26'd0, 26'd300}); end
    endtask

    task automatic test_t3;
        int lat; logic signed [25:0] d; logic [1:0] c;
        cfg_write(1, 2, 1 << 8);
        launch(1, 50);
        wait_out(lat, d, c);
        checks++; if (d !== 26'sd0) begin failures++; $display("FAIL t3_neg_clamp got=%0d exp=0", d); end
        checks++; if (c !== 2'd1) begin failures++; $display("FAIL t3_out_ch got=%0d exp=1", c); end
        cfg_write(1, 0, 100);
        launch(1, 50);
        wait_out(lat, d, c);
        checks++; if (d !== 26'sd50) begin failures++; $display("FAIL t3_restart got=%0d exp=50", d); end
        checks++; if (out_all[25:0] !== 26'd300) begin failures++; $display("FAIL t3_ch0_kept got=%0d exp=300", out_all[25:0]); end
    endtask

    task automatic test_t4;
        int lat; logic signed [25:0] d; logic [1:0] c;
        int e;
        cfg_write(2, 0, 1000);
        cfg_write(2, 2, 1 << 8);
        for (int k = 1; k <= 11; k++) begin
            launch(2, 0);
            wait_out(lat, d, c);
            e = (k * 100 > 1000) ? 1000 : k * 100;
            checks++; if (d !== 26'(e)) begin failures++; $display("FAIL t4_step%0d got=%0d exp=%0d", k, d, e); end
        end
        launch(2, 1050);
        wait_out(lat, d, c);
        checks++; if (d !== 26'sd950) begin failures++; $display("FAIL t4_no_windup got=%0d exp=950", d); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] chs [4];
        int smp [4];
        int expd [4];
        int acyc [4];
        int ocyc [4];
        int od [4];
        int oc [4];
        int na, no;
        logic acc;
        chs = '{2'd0, 2'd2, 2'd0, 2'd2};
        smp = '{400, 1050, 400, 1050};
        expd = '{400, 900, 500, 850};
        for (int k = 0; k < 4; k++) begin acyc[k] = -100; ocyc[k] = -1000; od[k] = -1; oc[k] = -1; end
        na = 0; no = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_ch = chs[0]; in_sample = 12'(smp[0]);
        for (int cyc = 0; cyc < 80 && no < 4; cyc++) begin
            @(negedge clk);
            if (out_valid && no < 4) begin
                ocyc[no] = cyc; od[no] = int'(out_data); oc[no] = int'(out_ch); no++;
            end
            acc = 1'b0;
            if (in_ready && in_valid && na < 4) begin
                acyc[na] = cyc; na++; acc = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (na < 4) begin in_ch = chs[na]; in_sample = 12'(smp[na]); end
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++; if (no !== 4) begin failures++; $display("FAIL b2b_out_count got=%0d exp=4", no); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (oc[k] !== int'(chs[k])) begin failures++; $display("FAIL b2b_out_ch%0d got=%0d exp=%0d", k, oc[k], chs[k]); end
            checks++; if (od[k] !== expd[k]) begin failures++; $display("FAIL b2b_out_data%0d got=%0d exp=%0d", k, od[k], expd[k]); end
            checks++; if (ocyc[k] - acyc[k] !== 9) begin failures++; $display("FAIL b2b_latency%0d got=%0d exp=9", k, ocyc[k] - acyc[k]); end
            if (k > 0) begin
                checks++; if (acyc[k] - acyc[k-1] !== 10) begin failures++; $display("FAIL b2b_interval%0d got=%0d exp=10", k, acyc[k] - acyc[k-1]); end
            end
        end
    endtask

    task automatic test_cfg_snapshot;
        int lat; logic signed [25:0] d; logic [1:0] c;
        cfg_write(3, 2, 1 << 8);
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_sel = 2'd0; cfg_data = 26'sd200;
        launch(3, 0);
        wait_out(lat, d, c);
        checks++; if (d !== 26'sd0) begin failures++; $display("FAIL snap_old_target got=%0d exp=0", d); end
        launch(3, 0);
        cfg_write(3, 2, 0);
        wait_out(lat, d, c);
        checks++; if (d !== 26'sd100) begin failures++; $display("FAIL snap_inflight got=%0d exp=100", d); end
        launch(3, 0);
        wait_out(lat, d, c);
        checks++; if (d !== 26'sd100) begin failures++; $display("FAIL snap_new_ki got=%0d exp=100", d); end
    endtask

    task automatic test_clr;
        int lat; logic signed [25:0] d; logic [1:0] c;
        int seen;
        seen = 0;
        launch(0, 400);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clr_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_all !== 104'd0) begin failures++; $display("FAIL clr_out_all got=%h exp=0", out_all); end
        checks++; if (out_data !== 26'sd0) begin failures++; $display("FAIL clr_out_data got=%0d exp=0", out_data); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL clr_no_out_valid got=%0d exp=0", seen); end
        launch(0, 400);
        wait_out(lat, d, c);
        checks++; if (d !== 26'sd100) begin failures++; $display("FAIL clr_cfg_ch0 got=%0d exp=100", d); end
        launch(2, 0);
        wait_out(lat, d, c);
        checks++; if (d !== 26'sd100) begin failures++; $display("FAIL clr_cfg_ch2 got=%0d exp=100", d); end
    endtask

    task automatic test_clr_vs_accept;
        int seen;
        seen = 0;
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_ch = 2'd0; in_sample = 12'd400;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL clrpri_no_out got=%0d exp=0", seen); end
        checks++; if (out_all !== 104'd0) begin failures++; $display("FAIL clrpri_out_all got=%h exp=0", out_all); end
    endtask

    task automatic test_reset_mid;
        int lat; logic signed [25:0] d; logic [1:0] c;
        launch(0, 400);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%0b exp=0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        launch(0, 400);
        wait_out(lat, d, c);
        checks++; if (lat !== 9) begin failures++; $display("FAIL rstmid_latency got=%0d exp=9", lat); end
        checks++; if (d !== 26'sd0) begin failures++; $display("FAIL rstmid_cfg_lost got=%0d exp=0", d); end
    endtask

    initial begin
        test_reset;
        test_t1;
        test_t2;
        test_t3;
        test_t4;
        test_back_to_back;
        test_cfg_snapshot;
        test_clr;
        test_clr_vs_accept;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
